free_list: RTL and testbench

//  Circular free list of physical register numbers (PRNs) for rename. Presents up to

---
 rtl/free_list.sv | 188 ++++++++++++++++++
 tb/tb_free_list.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/free_list.sv
// ---------------------------------------------------------------------------
// free_list
//
// Circular free list of physical register numbers (PRNs) for the rename stage.
// The list holds the PRNs that are currently free. It offers up to
// MACHINE_WIDTH of them per cycle, and retire pushes stale PRNs back onto it.
//
// The list uses three pointers. Each pointer is log2(FL_DEPTH)+1 bits wide, and
// its MSB is the wrap bit.
//   r_head     : next PRN to hand to rename (speculative allocation point)
//   r_cmt_head : allocation point as seen by retired (committed) ops
//   r_tail     : next slot that a retired stale PRN is written into
// Slots between r_cmt_head and r_head hold PRNs that have been handed out
// speculatively. Flush moves r_head back to r_cmt_head, so those PRNs become
// free again without being copied anywhere.
//
// Handshake: free_prn_valid[i] && free_prn_ready[i] at a rising clk edge
// transfers free_prn[i] to rename. Valid does not depend on ready. Rename must
// drive ready as a contiguous prefix from lane 0. Ready on an invalid lane has
// no effect.
//
// Ports
//   clk             in   clock
//   rst_n           in   asynchronous active-low reset
//   pipe_flush      in   squash all unretired ops; allocation is blocked
//   free_prn        out  MACHINE_WIDTH x PRF_WIDTH offered PRNs
//   free_prn_valid  out  MACHINE_WIDTH lane offers a PRN
//   free_prn_ready  in   MACHINE_WIDTH rename takes lane
//   retire_prn      in   RETIRE_WIDTH x PRF_WIDTH stale PRNs released
//   retire_valid    in   RETIRE_WIDTH retire lane active (contiguous prefix)
//   free_count      out  registered number of free PRNs held
// ---------------------------------------------------------------------------
module free_list #(
  parameter int PRF_DEPTH     = 64,
  parameter int PRF_WIDTH     = 6,
  parameter int ARF_DEPTH     = 32,
  parameter int MACHINE_WIDTH = 4,
  parameter int RETIRE_WIDTH  = 4
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    pipe_flush,
  output logic [MACHINE_WIDTH-1:0][PRF_WIDTH-1:0] free_prn,
  output logic [MACHINE_WIDTH-1:0]                free_prn_valid,
  input  logic [MACHINE_WIDTH-1:0]                free_prn_ready,
  input  logic [RETIRE_WIDTH-1:0][PRF_WIDTH-1:0]  retire_prn,
  input  logic [RETIRE_WIDTH-1:0]                 retire_valid,
  output logic [$clog2(PRF_DEPTH-ARF_DEPTH):0]    free_count
);

  localparam int FL_DEPTH = PRF_DEPTH - ARF_DEPTH;
  localparam int IDX_W    = $clog2(FL_DEPTH);
  localparam int PTR_W    = IDX_W + 1;
  localparam int ACNT_W   = $clog2(MACHINE_WIDTH + 1);
  localparam int RCNT_W   = $clog2(RETIRE_WIDTH + 1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [PRF_WIDTH-1:0] r_fl [FL_DEPTH];
  logic [PTR_W-1:0]     r_head;
  logic [PTR_W-1:0]     r_cmt_head;
  logic [PTR_W-1:0]     r_tail;
  logic [PTR_W-1:0]     r_free_count;

  // -------------------------------------------------------------------------
  // Next-state wires
  // -------------------------------------------------------------------------
  logic [PTR_W-1:0]         w_count;
  logic [MACHINE_WIDTH-1:0] w_take;
  logic [ACNT_W-1:0]        w_n_alloc;
  logic [RCNT_W-1:0]        w_n_ret;
  logic [PTR_W-1:0]         w_head_next;
  logic [PTR_W-1:0]         w_cmt_head_next;
  logic [PTR_W-1:0]         w_tail_next;
  logic [PTR_W-1:0]         w_count_next;
  logic                     w_rdy_prefix;
  logic                     w_ret_prefix;

  function automatic logic [ACNT_W-1:0] pop_alloc(input logic [MACHINE_WIDTH-1:0] v);
    logic [ACNT_W-1:0] c;
    c = '0;
    for (int k = 0; k < MACHINE_WIDTH; k++) begin
      c = c + ACNT_W'(v[k]);
    end
    return c;
  endfunction

  function automatic logic [RCNT_W-1:0] pop_ret(input logic [RETIRE_WIDTH-1:0] v);
    logic [RCNT_W-1:0] c;
    c = '0;
    for (int k = 0; k < RETIRE_WIDTH; k++) begin
      c = c + RCNT_W'(v[k]);
    end
    return c;
  endfunction

  // The modulo pointer difference gives the occupancy, including after a wrap.
  assign w_count = r_tail - r_head;

  // The offer is a pure function of the registered state. A PRN retired in this
  // cycle is not offered until it has been written into the list.
  always_comb begin
    free_prn       = '0;
    free_prn_valid = '0;
    for (int i = 0; i < MACHINE_WIDTH; i++) begin
      free_prn[i]       = r_fl[r_head[IDX_W-1:0] + IDX_W'(i)];
      free_prn_valid[i] = (w_count > PTR_W'(i)) && !pipe_flush;
    end
  end

  assign w_take    = free_prn_valid & free_prn_ready;
  assign w_n_alloc = pop_alloc(w_take);
  assign w_n_ret   = pop_ret(retire_valid);

  // A value with no zero below any one bit satisfies x & (x+1) == 0.
  assign w_rdy_prefix = ((free_prn_ready & (free_prn_ready + MACHINE_WIDTH'(1))) == '0);
  assign w_ret_prefix = ((retire_valid & (retire_valid + RETIRE_WIDTH'(1))) == '0);

  // Each retiring op commits one earlier allocation. On a flush, head rewinds
  // to the committed point, including this cycle's commits. Every
  // speculatively allocated PRN is therefore free again. Valid is forced low
  // during a flush, so w_n_alloc is zero in that cycle.
  assign w_cmt_head_next = r_cmt_head + PTR_W'(w_n_ret);
  assign w_tail_next     = r_tail + PTR_W'(w_n_ret);
  assign w_head_next     = pipe_flush ? w_cmt_head_next : (r_head + PTR_W'(w_n_alloc));
  assign w_count_next    = w_tail_next - w_head_next;

  assign free_count = r_free_count;

  // -------------------------------------------------------------------------
  // Sequential state
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // PRNs 0..ARF_DEPTH-1 are the architectural mapping at reset. The rest
      // of the PRNs start out free, in ascending order.
      for (int k = 0; k < FL_DEPTH; k++) begin
        r_fl[k] <= PRF_WIDTH'(ARF_DEPTH + k);
      end
      r_head       <= '0;
      r_cmt_head   <= '0;
      r_tail       <= PTR_W'(FL_DEPTH);
      r_free_count <= PTR_W'(FL_DEPTH);
    end else begin
      for (int j = 0; j < RETIRE_WIDTH; j++) begin
        if (RCNT_W'(j) < w_n_ret) begin
          r_fl[r_tail[IDX_W-1:0] + IDX_W'(j)] <= retire_prn[j];
        end
      end
      r_head       <= w_head_next;
      r_cmt_head   <= w_cmt_head_next;
      r_tail       <= w_tail_next;
      r_free_count <= w_count_next;
    end
  end

  // -------------------------------------------------------------------------
  // Usage checks
  // -------------------------------------------------------------------------
  always @(posedge clk) begin
    if (rst_n) begin
      assert (w_rdy_prefix)
        else $error("free_list: free_prn_ready is not a contiguous prefix");
      assert (w_ret_prefix)
        else $error("free_list: retire_valid is not a contiguous prefix");
      assert (w_count_next <= PTR_W'(FL_DEPTH))
        else $error("free_list: free count would exceed list capacity");
      // If the committed pointer overtakes head, the difference wraps and the
      // result is far larger than the list capacity.
      assert ((w_head_next - w_cmt_head_next) <= PTR_W'(FL_DEPTH))
        else $error("free_list: cmt_head passed head");
      for (int j = 0; j < RETIRE_WIDTH; j++) begin
        if (RCNT_W'(j) < w_n_ret) begin
          assert ({1'b0, retire_prn[j]} < (PRF_WIDTH + 1)'(PRF_DEPTH))
            else $error("free_list: retire_prn out of range");
          for (int i = 0; i < MACHINE_WIDTH; i++) begin
            if (free_prn_valid[i]) begin
              assert (retire_prn[j] != free_prn[i])
                else $error("free_list: retired PRN is currently offered as free");
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_free_list.sv
// ---------------------------------------------------------------------------
// tb_free_list
//
// Bench for free_list. Its reference model tracks three disjoint pools of PRNs:
//   m_free  : free PRNs, in the order the list will hand them out
//   m_spec  : PRNs allocated to rename but not yet committed by retire
//   m_owned : PRNs that hold architectural state (32 entries at all times)
// Retiring an op commits the oldest entry of m_spec into m_owned. It also
// moves the op's stale PRN from m_owned to the back of m_free. A flush puts
// the uncommitted PRNs back at the front of the free order.
// ---------------------------------------------------------------------------
module tb_free_list;

  localparam int MW = 4;
  localparam int RW = 4;
  localparam int PW = 6;

  // -------------------------------------------------------------------------
  // Clock / reset and DUT
  // -------------------------------------------------------------------------
  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   pipe_flush = 1'b0;
  logic [MW-1:0][PW-1:0]  free_prn;
  logic [MW-1:0]          free_prn_valid;
  logic [MW-1:0]          free_prn_ready = '0;
  logic [RW-1:0][PW-1:0]  retire_prn = '0;
  logic [RW-1:0]          retire_valid = '0;
  logic [5:0]             free_count;

  always #5 clk = ~clk;

  free_list dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pipe_flush     (pipe_flush),
    .free_prn       (free_prn),
    .free_prn_valid (free_prn_valid),
    .free_prn_ready (free_prn_ready),
    .retire_prn     (retire_prn),
    .retire_valid   (retire_valid),
    .free_count     (free_count)
  );

  // -------------------------------------------------------------------------
  // Scoreboard state
  // -------------------------------------------------------------------------
  int n_cmp  = 0;
  int n_fail = 0;

  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] m_free[$];
  logic [PW-1:0] m_spec[$];
  logic [PW-1:0] m_owned[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every accepted lane must carry the next PRN that the stimulus
  // side predicted.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < MW; i++) begin
        if (free_prn_valid[i] && free_prn_ready[i]) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL alloc_lane%0d: got %0d, expected no allocation", i, free_prn[i]);
          end else begin
            check($sformatf("alloc_lane%0d", i), int'(free_prn[i]), int'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic model_reset();
    m_free  = {};
    m_spec  = {};
    m_owned = {};
    exp_q   = {};
    for (int k = 0; k < 32; k++) begin
      m_owned.push_back(PW'(k));
      m_free.push_back(PW'(32 + k));
    end
  endtask

  task automatic do_reset();
    free_prn_ready = '0;
    retire_valid   = '0;
    retire_prn     = '0;
    pipe_flush     = 1'b0;
    rst_n          = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One clock cycle. The task is entered just after a rising edge. rdy_n and
  // ret_n are prefix lengths. The caller only retires ops that have an
  // uncommitted allocation, and only with stale PRNs in m_owned.
  task automatic cycle(input int rdy_n, input int ret_n,
                       input logic [PW-1:0] s0, input logic [PW-1:0] s1,
                       input logic [PW-1:0] s2, input logic [PW-1:0] s3,
                       input bit flush);
    logic [PW-1:0] st[4];
    logic [PW-1:0] ret_l[$];
    int            n_alloc;
    int            n_avail;
    st = '{s0, s1, s2, s3};
    free_prn_ready = MW'((1 << rdy_n) - 1);
    retire_valid   = RW'((1 << ret_n) - 1);
    for (int j = 0; j < RW; j++) begin
      retire_prn[j] = (j < ret_n) ? st[j] : '0;
    end
    pipe_flush = flush;

    n_avail = (m_free.size() < MW) ? m_free.size() : MW;
    n_alloc = flush ? 0 : ((rdy_n < n_avail) ? rdy_n : n_avail);
    for (int k = 0; k < n_alloc; k++) begin
      exp_q.push_back(m_free[k]);
    end

    @(negedge clk);
    check("free_count", int'(free_count), m_free.size());
    check("valid_mask", int'(free_prn_valid), flush ? 0 : ((1 << n_avail) - 1));
    check("count_bound", int'(free_count <= 6'd32), 1);

    for (int k = 0; k < n_alloc; k++) begin
      m_spec.push_back(m_free.pop_front());
    end
    for (int j = 0; j < ret_n; j++) begin
      m_owned.push_back(m_spec.pop_front());
      for (int k = 0; k < m_owned.size(); k++) begin
        if (m_owned[k] == st[j]) begin
          m_owned.delete(k);
          break;
        end
      end
      ret_l.push_back(st[j]);
    end
    if (flush) begin
      m_free = {m_spec, m_free, ret_l};
      m_spec = {};
    end else begin
      m_free = {m_free, ret_l};
    end

    @(posedge clk);
    #1;
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    int            rdy;
    int            ret;
    int            base;
    int            max_ret;
    bit            fl;
    logic [PW-1:0] s[4];

    do_reset();

    // Reset state
    check("rst_prn0", int'(free_prn[0]), 32);
    check("rst_prn1", int'(free_prn[1]), 33);
    check("rst_prn2", int'(free_prn[2]), 34);
    check("rst_prn3", int'(free_prn[3]), 35);
    check("rst_valid", int'(free_prn_valid), 4'b1111);
    check("rst_count", int'(free_count), 32);

    // Drain the list completely, then keep ready high while it is empty.
    repeat (8) cycle(4, 0, 0, 0, 0, 0, 0);
    check("empty_valid", int'(free_prn_valid), 0);
    check("empty_count", int'(free_count), 0);
    cycle(4, 0, 0, 0, 0, 0, 0);
    check("empty_hold_count", int'(free_count), 0);

    // Retire two lanes from empty; those PRNs are the only ones offered.
    cycle(0, 2, 6'd5, 6'd9, 0, 0, 0);
    check("refill_prn0", int'(free_prn[0]), 5);
    check("refill_prn1", int'(free_prn[1]), 9);
    check("refill_valid", int'(free_prn_valid), 4'b0011);
    check("refill_count", int'(free_count), 2);

    // Allocate 8, retire 2, flush: the six uncommitted PRNs are free again.
    do_reset();
    repeat (2) cycle(4, 0, 0, 0, 0, 0, 0);
    cycle(0, 2, 6'd1, 6'd2, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1);
    check("flush_prn0", int'(free_prn[0]), 34);
    check("flush_prn1", int'(free_prn[1]), 35);
    check("flush_prn2", int'(free_prn[2]), 36);
    check("flush_prn3", int'(free_prn[3]), 37);
    check("flush_count", int'(free_count), 32);

    // Simultaneous allocate 2 and retire 3 at count 10.
    do_reset();
    repeat (5) cycle(4, 0, 0, 0, 0, 0, 0);
    cycle(2, 0, 0, 0, 0, 0, 0);
    check("pre_mix_count", int'(free_count), 10);
    cycle(2, 3, 6'd3, 6'd4, 6'd5, 0, 0);
    check("mix_count", int'(free_count), 11);
    repeat (2) cycle(4, 0, 0, 0, 0, 0, 0);
    check("tail_prn0", int'(free_prn[0]), 3);
    check("tail_prn1", int'(free_prn[1]), 4);
    check("tail_prn2", int'(free_prn[2]), 5);
    check("tail_valid", int'(free_prn_valid), 4'b0111);

    // Reset asserted mid-cycle while a handshake is pending.
    free_prn_ready = 4'b1111;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_count", int'(free_count), 32);
    check("midrst_prn0", int'(free_prn[0]), 32);
    check("midrst_prn3", int'(free_prn[3]), 35);
    free_prn_ready = '0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Several wraps of random allocate / retire / occasional flush.
    for (int c = 0; c < 400; c++) begin
      rdy     = $urandom_range(0, 4);
      max_ret = (m_spec.size() < RW) ? m_spec.size() : RW;
      ret     = $urandom_range(0, max_ret);
      base    = $urandom_range(0, 32 - ret);
      fl      = ($urandom_range(0, 15) == 0);
      for (int j = 0; j < 4; j++) begin
        s[j] = (j < ret) ? m_owned[base + j] : '0;
      end
      cycle(rdy, ret, s[0], s[1], s[2], s[3], fl);
    end
    cycle(0, 0, 0, 0, 0, 0, 0);
    check("exp_q_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
